// File: rtl/vdp_cpu_if.sv
// Z180 host port for the VDP: TMS9918-style data/control ports that fill
// VRAM, hold the border and interrupt-enable registers, and flag vblank.
module vdp_cpu_if #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_cs_n,
  input  logic        cpu_wr_n,
  input  logic        cpu_rd_n,
  input  logic        cpu_a0,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  input  logic        vsync_in,
  output logic [11:0] vram_waddr,
  output logic [7:0]  vram_wdata,
  output logic        name_we,
  output logic        colour_we,
  output logic        pattern_we,
  output logic [3:0]  border_colour_out,
  output logic        irq_n
);

  // Index 0 = write strobe, 1 = read strobe; both active at once counts as neither.
  logic [1:0] strobe_raw;
  assign strobe_raw[0] = ~cpu_cs_n & ~cpu_wr_n & cpu_rd_n;
  assign strobe_raw[1] = ~cpu_cs_n & ~cpu_rd_n & cpu_wr_n;

  logic [SYNC_STAGES-1:0] vld_reg;
  logic [1:0] sync_last, prev_last, armed, rise, fall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) vld_reg <= '0;
    else        vld_reg <= {vld_reg[SYNC_STAGES-2:0], 1'b1};
  end

  // A strobe only arms after a genuine idle sample, so one held across reset release is ignored.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      logic [SYNC_STAGES-1:0] chain_reg;
      logic                   prev_reg;
      logic                   armed_reg;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          chain_reg <= '0;
          prev_reg  <= 1'b0;
          armed_reg <= 1'b0;
        end else begin
          chain_reg <= {chain_reg[SYNC_STAGES-2:0], strobe_raw[gi]};
          prev_reg  <= chain_reg[SYNC_STAGES-1];
          armed_reg <= armed_reg | (vld_reg[SYNC_STAGES-1] & ~chain_reg[SYNC_STAGES-1]);
        end
      end

      assign sync_last[gi] = chain_reg[SYNC_STAGES-1];
      assign prev_last[gi] = prev_reg;
      assign armed[gi]     = armed_reg;
      assign rise[gi]      = sync_last[gi] & ~prev_reg & armed_reg;
      assign fall[gi]      = ~sync_last[gi] & prev_reg & armed_reg;
    end
  endgenerate

  logic        wr_evt_reg, wr_a0_reg, rd_a0_reg;
  logic [7:0]  wr_din_reg, snap_reg, rdbuf_reg, latch_reg;
  logic [11:0] addr_reg;
  logic        toggle_reg, ie_reg, vbf_reg, vsync_reg;
  logic [3:0]  r0_reg;
  logic        vsync_rise, status_clear;

  assign vsync_rise   = vsync_in & ~vsync_reg;
  assign status_clear = fall[1] & rd_a0_reg;

  // Capture the bus on the detected edge; act on it one cycle later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_evt_reg <= 1'b0;
      wr_a0_reg  <= 1'b0;
      wr_din_reg <= 8'h00;
      rd_a0_reg  <= 1'b0;
      snap_reg   <= 8'hFF;
    end else begin
      wr_evt_reg <= rise[0];
      if (rise[0]) begin
        wr_a0_reg  <= cpu_a0;
        wr_din_reg <= cpu_din;
      end
      if (rise[1]) begin
        rd_a0_reg <= cpu_a0;
        snap_reg  <= cpu_a0 ? {vbf_reg, 7'b0} : rdbuf_reg;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_reg   <= 12'h000;
      latch_reg  <= 8'h00;
      toggle_reg <= 1'b0;
      rdbuf_reg  <= 8'h00;
      r0_reg     <= 4'h0;
      ie_reg     <= 1'b0;
      vram_waddr <= 12'h000;
      vram_wdata <= 8'h00;
      name_we    <= 1'b0;
      colour_we  <= 1'b0;
      pattern_we <= 1'b0;
    end else begin
      name_we    <= 1'b0;
      colour_we  <= 1'b0;
      pattern_we <= 1'b0;
      if (wr_evt_reg) begin
        if (!wr_a0_reg) begin
          vram_waddr <= addr_reg;
          vram_wdata <= wr_din_reg;
          name_we    <= (addr_reg[11:10] == 2'b00);
          colour_we  <= (addr_reg[11:10] == 2'b01);
          pattern_we <= addr_reg[11];
          addr_reg   <= addr_reg + 12'd1;
          rdbuf_reg  <= wr_din_reg;
          toggle_reg <= 1'b0;
        end else if (!toggle_reg) begin
          latch_reg  <= wr_din_reg;
          toggle_reg <= 1'b1;
        end else begin
          toggle_reg <= 1'b0;
          if (wr_din_reg[7]) begin
            if (wr_din_reg[2:0] == 3'd0) r0_reg <= latch_reg[3:0];
            if (wr_din_reg[2:0] == 3'd1) ie_reg <= latch_reg[5];
          end else begin
            addr_reg <= {wr_din_reg[3:0], latch_reg};
          end
        end
      end
      if (fall[1]) toggle_reg <= 1'b0;
    end
  end

  // A vblank edge in the same cycle as a status-read clear leaves the flag set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vsync_reg <= 1'b0;
      vbf_reg   <= 1'b0;
      irq_n     <= 1'b1;
    end else begin
      vsync_reg <= vsync_in;
      if (vsync_rise)        vbf_reg <= 1'b1;
      else if (status_clear) vbf_reg <= 1'b0;
      irq_n <= ~(vbf_reg & ie_reg);
    end
  end

  assign border_colour_out = r0_reg;
  assign cpu_dout = (prev_last[1] & strobe_raw[1]) ? snap_reg : 8'hFF;

endmodule

// File: doc/vdp_cpu_if.md
# vdp_cpu_if

CPU-side host interface for the VDP: the Z180 write/read port that fills the name, colour and pattern RAMs the tile renderer reads, and holds the border-colour and interrupt registers. It sits upstream of the VDP. It turns asynchronous Z180 bus strobes into single-cycle VRAM write pulses through a TMS9918-style two-port protocol: a data port and a control port. It also produces the vertical-blank status flag and the interrupt request.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchronizer depth on `cpu_cs_n`, `cpu_wr_n` and `cpu_rd_n`. Minimum 2.

Ports:
- `clk`  in  1  pixel clock; same clock as the VDP.
- `reset`  in  1  asynchronous, active-low reset.
- `cpu_cs_n`  in  1  chip select, active low; asynchronous to `clk`.
- `cpu_wr_n`  in  1  write strobe, active low; asynchronous.
- `cpu_rd_n`  in  1  read strobe, active low; asynchronous.
- `cpu_a0`  in  1  port select: 0 = data port, 1 = control port.
- `cpu_din`  in  8  CPU write data.
- `cpu_dout`  out  8  CPU read data.
- `vsync_in`  in  1  active-high vertical sync from the VGA timing generator.
- `vram_waddr`  out  12  unified VRAM byte address.
- `vram_wdata`  out  8  VRAM write data.
- `name_we`  out  1  write enable, name RAM; address = `vram_waddr[9:0]`.
- `colour_we`  out  1  write enable, colour RAM; address = `vram_waddr[9:0]`.
- `pattern_we`  out  1  write enable, pattern RAM; address = `vram_waddr[10:0]`.
- `border_colour_out`  out  4  drives the VDP border colour input.
- `irq_n`  out  1  interrupt request, active low.

## Operation
- **Strobe synchronization.**
  - Internal write strobe: `wr = ~cpu_cs_n & ~cpu_wr_n`. Internal read strobe: `rd = ~cpu_cs_n & ~cpu_rd_n`.
  - Each strobe passes through `SYNC_STAGES` flops followed by an edge-detect flop.
  - A write acts on the synchronized rising edge of `wr`.
  - On the rising edge of `rd`, the read data is snapshotted. Read side effects act on the falling edge of `rd`.
  - `cpu_din` and `cpu_a0` are sampled on the cycle the edge is detected.
- **Address map** (`addr`, 12 bits):
  - 0x000–0x3FF: name RAM.
  - 0x400–0x7FF: colour RAM.
  - 0x800–0xFFF: pattern RAM.
  - Exactly one `*_we` pulses per data write, selected by `addr[11:10]`: 00 = name, 01 = colour, 1x = pattern.
- **Data port write (a0=0).**
  - `vram_waddr` ← `addr`; `vram_wdata` ← din; the selected `*_we` pulses for 1 cycle.
  - Then `addr` ← `addr` + 1, wrapping 0xFFF→0x000.
  - `rdbuf` ← din.
  - `toggle` ← 0.
- **Data port read (a0=0).** `cpu_dout` = `rdbuf`, the last byte written. At the strobe end, `toggle` ← 0. No VRAM read takes place.
- **Control port write (a0=1).** `toggle` selects the byte position.
  - `toggle`=0: `latch` ← din; `toggle` ← 1.
  - `toggle`=1, din[7]=1: register write. Register din[2:0] ← `latch`; `toggle` ← 0.
  - `toggle`=1, din[7]=0: address set. `addr` ← {din[3:0], `latch`}; `toggle` ← 0. din[6:4] are ignored.
- **Registers.**
  - R0[3:0]: `border_colour_out`.
  - R1[5]: `ie`, interrupt enable.
  - Writes to R2–R7 are ignored, apart from clearing `toggle`.
- **Control port read (a0=1).**
  - `cpu_dout` = {`vbf`, 7'b0}, snapshotted at the strobe's rising edge.
  - At the strobe's falling edge: `vbf` ← 0; `toggle` ← 0.
- **Vertical blank.**
  - `vbf` ← 1 on a rising edge of `vsync_in`, which is registered once internally.
  - `irq_n` = ~(`vbf` & `ie`), driven from a flop.
- **Bus contention.** If `cpu_cs_n`=1, or the strobe is deasserted, `cpu_dout` = 0xFF. `cpu_dout` is combinational from the snapshot register gated by the synchronized `rd`.

## Timing
- **Reset values** (asynchronous, all registers):
  - `addr`=0, `latch`=0, `toggle`=0, `rdbuf`=0, R0=0, `ie`=0, `vbf`=0.
  - `vram_waddr`=0, `vram_wdata`=0, all `*_we`=0.
  - `border_colour_out`=0, `irq_n`=1, `cpu_dout`=0xFF.
  - Synchronizers reset to "strobe inactive".
- **Write latency.** `*_we` asserts exactly `SYNC_STAGES`+1 cycles after the first `clk` edge that samples `wr`=1.
  - It stays high for exactly 1 cycle.
  - `vram_waddr`/`vram_wdata` are registered and valid in that same cycle.
- **Post-write updates.**
  - `addr` increments in the cycle after `*_we`.
  - A register write is visible on `border_colour_out`/`irq_n` `SYNC_STAGES`+2 cycles after strobe assertion.
- **CPU strobe requirements.**
  - Strobe low ≥ `SYNC_STAGES`+2 clk.
  - Strobe high between accesses ≥ `SYNC_STAGES`+1 clk.
  - `cpu_din`/`cpu_a0` stable for the whole strobe.
  - One access per strobe, irrespective of its length.
- **vblank edge colliding with a status-read clear.** If a `vsync_in` rising edge and a status-read clear occur in the same cycle, set wins: `vbf` stays 1.
- **Reset mid-access.** All state clears immediately. A strobe still held low when `reset` deasserts does not cause an action, because edge detection needs a high→low transition of the strobe.
- **Unknown strobe state.** A simultaneous `wr` and `rd` are both ignored.

## Test plan
- **Reset.**
  - Stimulus: hold `reset`=0 with random bus activity.
  - Required: all outputs at their reset values; no `*_we` pulse; `irq_n`=1.
- **Address set and sequential writes.**
  - Stimulus: control writes 0x00 then 0x48 (addr=0x800); data writes 0xAA, 0x55.
  - Required: `pattern_we` pulses twice, with `vram_waddr` 0x800/0x801 and `vram_wdata` 0xAA/0x55; `name_we` and `colour_we` stay 0.
- **Wrap-around.**
  - Stimulus: set addr=0xFFF (0xFF, 0x0F); write 0x11 then 0x22.
  - Required: writes land at 0xFFF (`pattern_we`), then 0x000 (`name_we`).
- **Register write.**
  - Stimulus: control writes 0x0C, 0x80.
  - Required: `border_colour_out`=0xC; `addr` unchanged; `toggle` back to 0.
- **Interrupt.**
  - Stimulus: write R1=0x20 (0x20, 0x81); pulse `vsync_in`.
  - Required: `irq_n`=0. A control read returns 0x80 and `irq_n`→1 after the strobe ends; a second control read returns 0x00.
- **Toggle reset by status read.**
  - Stimulus: control write 0x34, then a control read, then control writes 0x00, 0x44.
  - Required: addr=0x400; the next data write pulses `colour_we` at 0x400.
